load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 37 +++
 rtl/lsu_lane_align.sv | 63 ++++++
 rtl/load_store_unit.sv | 131 +++++++++++++
 tb/tb_load_store_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// ---------------------------------------------------------------------------
// load_store_unit_pkg
// Shared definitions for the load/store unit. It holds the access-size
// encodings, the controller state enum and the alignment check that is used
// when a request is accepted.
// ---------------------------------------------------------------------------
package load_store_unit_pkg;

    // Access-size encodings carried on req_size. The value 2'b11 is illegal.
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        READ  = 2'b01,
        WRITE = 2'b10,
        RESP  = 2'b11
    } lsu_state_t;

    // Returns 1 when a request can never be carried out. This covers an
    // illegal size, a halfword on an odd byte and a word that is not on a
    // word boundary.
    function automatic logic lsu_bad_request(input logic [1:0] size,
                                             input logic [1:0] offset);
        logic bad;
        bad = 1'b0;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = (offset != 2'b00);
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// ---------------------------------------------------------------------------
// lsu_lane_align
// Combinational lane logic for the load/store unit. Memory words are
// big-endian, so the byte at offset 0 sits in bits [31:24].
//   size      in  2   access size (SZ_BYTE / SZ_HALF / SZ_WORD)
//   offset    in  2   byte offset inside the word
//   sign_ext  in  1   sign-extend byte and halfword loads
//   rd_word   in  32  word read from memory
//   wdata     in  32  store data, right-justified
//   load_data out 32  extracted and extended load result
//   merged    out 32  rd_word with the addressed lane(s) replaced by wdata
// ---------------------------------------------------------------------------
module lsu_lane_align
    import load_store_unit_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  offset,
    input  logic        sign_ext,
    input  logic [31:0] rd_word,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merged
);

    logic [7:0] rd_byte     [4];
    logic [7:0] merged_byte [4];

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);

            assign rd_byte[gi] = rd_word[31-8*gi -: 8];

            // A halfword store covers the two lanes whose offset[1] matches.
            // The even lane of the pair takes the high byte of the halfword.
            assign merged_byte[gi] =
                (size == SZ_WORD) ? wdata[31-8*gi -: 8] :
                (size == SZ_HALF) ? ((offset[1] == LANE[1]) ?
                                        (LANE[0] ? wdata[7:0] : wdata[15:8]) :
                                        rd_byte[gi]) :
                                    ((offset == LANE) ? wdata[7:0] : rd_byte[gi]);
        end
    endgenerate

    assign merged = {merged_byte[0], merged_byte[1], merged_byte[2], merged_byte[3]};

    logic [7:0]  sel_byte;
    logic [15:0] sel_half;

    assign sel_byte = rd_byte[offset];
    assign sel_half = offset[1] ? rd_word[15:0] : rd_word[31:16];

    always_comb begin
        load_data = rd_word;
        case (size)
            SZ_BYTE: load_data = {{24{sign_ext & sel_byte[7]}}, sel_byte};
            SZ_HALF: load_data = {{16{sign_ext & sel_half[15]}}, sel_half};
            default: load_data = rd_word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// ---------------------------------------------------------------------------
// load_store_unit
// This module handles single-outstanding loads and stores to a word-wide,
// big-endian memory with a combinational read path. A byte or halfword store
// is done as a read-modify-write. A misaligned or illegal-size request gets
// an error response without touching memory.
//   clk, rst_n                      clock, asynchronous active-low reset
//   req_valid/req_ready             request handshake (ready only in IDLE)
//   req_we, req_size, req_signed    request kind
//   req_addr, req_wdata             byte address, right-justified store data
//   resp_valid, resp_rdata, resp_err  one-cycle completion
//   data_addr, data_wr, data_out    memory address, write strobe, write data
//   data_in                         memory read data for data_addr
// All outputs are registered.
// ---------------------------------------------------------------------------
module load_store_unit
    import load_store_unit_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic [31:0] data_addr,
    output logic        data_wr,
    output logic [31:0] data_out,
    input  logic [31:0] data_in
);

    lsu_state_t  state_reg;
    logic        we_reg;
    logic [1:0]  size_reg;
    logic        signed_reg;
    logic [1:0]  offset_reg;
    logic [31:0] wdata_reg;

    logic [31:0] load_data;
    logic [31:0] merged;

    lsu_lane_align u_lane_align (
        .size      (size_reg),
        .offset    (offset_reg),
        .sign_ext  (signed_reg),
        .rd_word   (data_in),
        .wdata     (wdata_reg),
        .load_data (load_data),
        .merged    (merged)
    );

    // Moving back to IDLE clears the response fields, so resp_rdata and
    // resp_err are nonzero only while resp_valid is high. The reset also
    // drops data_wr at once, so a store that is abandoned never reaches
    // memory.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            req_ready  <= 1'b1;
            resp_valid <= 1'b0;
            resp_rdata <= '0;
            resp_err   <= 1'b0;
            data_addr  <= '0;
            data_wr    <= 1'b0;
            data_out   <= '0;
            we_reg     <= 1'b0;
            size_reg   <= SZ_BYTE;
            signed_reg <= 1'b0;
            offset_reg <= '0;
            wdata_reg  <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req_valid && req_ready) begin
                        we_reg     <= req_we;
                        size_reg   <= req_size;
                        signed_reg <= req_signed;
                        offset_reg <= req_addr[1:0];
                        wdata_reg  <= req_wdata;
                        data_addr  <= {req_addr[31:2], 2'b00};
                        req_ready  <= 1'b0;
                        if (lsu_bad_request(req_size, req_addr[1:0])) begin
                            state_reg  <= RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= '0;
                        end else if (req_we && (req_size == SZ_WORD)) begin
                            // A full-word store needs no read.
                            state_reg <= WRITE;
                            data_wr   <= 1'b1;
                            data_out  <= req_wdata;
                        end else begin
                            state_reg <= READ;
                        end
                    end
                end
                READ: begin
                    // data_in is valid for the registered data_addr here.
                    if (we_reg) begin
                        state_reg <= WRITE;
                        data_wr   <= 1'b1;
                        data_out  <= merged;
                    end else begin
                        state_reg  <= RESP;
                        resp_valid <= 1'b1;
                        resp_rdata <= load_data;
                    end
                end
                WRITE: begin
                    state_reg  <= RESP;
                    data_wr    <= 1'b0;
                    resp_valid <= 1'b1;
                    resp_rdata <= '0;
                end
                default: begin
                    state_reg  <= IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= '0;
                    req_ready  <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    localparam logic [1:0] B = 2'b00;
    localparam logic [1:0] H = 2'b01;
    localparam logic [1:0] W = 2'b10;
    localparam logic [1:0] X = 2'b11;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic        req_signed = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [31:0] data_addr;
    logic        data_wr;
    logic [31:0] data_out;
    logic [31:0] data_in;

    always #5 clk = ~clk;

    load_store_unit dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_size   (req_size),
        .req_signed (req_signed),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_rdata (resp_rdata),
        .resp_err   (resp_err),
        .data_addr  (data_addr),
        .data_wr    (data_wr),
        .data_out   (data_out),
        .data_in    (data_in)
    );

    // Memory model: 64 big-endian words, combinational read, posedge write.
    logic [31:0] mem [64];
    logic        pre_en = 1'b0;
    logic [5:0]  pre_idx = '0;
    logic [31:0] pre_data = '0;

    assign data_in = mem[data_addr[7:2]];

    always @(posedge clk) begin
        if (data_wr)
            mem[data_addr[7:2]] <= data_out;
        else if (pre_en)
            mem[pre_idx] <= pre_data;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        @(negedge clk);
        pre_idx  = 6'(idx);
        pre_data = val;
        pre_en   = 1'b1;
        @(negedge clk);
        pre_en   = 1'b0;
    endtask

    // Runs one request and returns the observed response. lat is the cycle,
    // counted from acceptance, in which resp_valid was seen (0 = never).
    task automatic do_req(input logic we, input logic [1:0] size, input logic sgn,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          output logic [31:0] rdata, output logic err,
                          output int lat, output int wr_cnt, output logic [31:0] daddr);
        int waited;
        rdata = '0; err = 1'b0; lat = 0; wr_cnt = 0; daddr = '0;
        waited = 0;
        @(negedge clk);
        while (!req_ready && waited < 20) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            n_cmp++; n_bad++;
            $display("FAIL ready_timeout: got 0 expected 1");
            return;
        end
        req_we = we; req_size = size; req_signed = sgn;
        req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        for (int c = 1; c <= 8; c++) begin
            @(negedge clk);
            if (data_wr) wr_cnt++;
            if (resp_valid) begin
                lat = c; rdata = resp_rdata; err = resp_err; daddr = data_addr;
                break;
            end
        end
    endtask

    typedef struct {
        logic        we;
        logic [1:0]  size;
        logic        sgn;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        logic        exp_err;
        int          exp_lat;
        int          exp_wr;
        int          mem_idx;
        logic [31:0] exp_mem;
    } vec_t;

    function automatic vec_t mk(logic we, logic [1:0] size, logic sgn, logic [31:0] addr,
                                logic [31:0] wdata, logic [31:0] er, logic ee, int el,
                                int ew, int mi, logic [31:0] em);
        vec_t v;
        v.we = we; v.size = size; v.sgn = sgn; v.addr = addr; v.wdata = wdata;
        v.exp_rdata = er; v.exp_err = ee; v.exp_lat = el; v.exp_wr = ew;
        v.mem_idx = mi; v.exp_mem = em;
        return v;
    endfunction

    vec_t vecs [18];

    initial begin
        logic [31:0] rd, da;
        logic        er;
        int          lat, wr;
        logic        rdy_seen [1:6];
        logic        rv_seen  [1:6];
        logic [31:0] rd_seen  [1:6];
        int          bad_cnt;

        // --- table: {we,size,sgn,addr,wdata, rdata,err,lat,wr, mem idx,word}
        vecs[0]  = mk(1, W, 0, 32'h10, 32'hDEADBEEF, 32'h0,        0, 2, 1,  4, 32'hDEADBEEF);
        vecs[1]  = mk(0, W, 0, 32'h10, 32'h0,        32'hDEADBEEF, 0, 2, 0,  4, 32'hDEADBEEF);
        vecs[2]  = mk(0, B, 1, 32'h23, 32'h0,        32'h00000044, 0, 2, 0, -1, 32'h0);
        vecs[3]  = mk(0, H, 1, 32'h20, 32'h0,        32'h00001122, 0, 2, 0, -1, 32'h0);
        vecs[4]  = mk(0, B, 1, 32'h28, 32'h0,        32'hFFFFFF80, 0, 2, 0, -1, 32'h0);
        vecs[5]  = mk(0, B, 0, 32'h28, 32'h0,        32'h00000080, 0, 2, 0, -1, 32'h0);
        vecs[6]  = mk(0, H, 1, 32'h28, 32'h0,        32'hFFFF80FF, 0, 2, 0, -1, 32'h0);
        vecs[7]  = mk(0, H, 0, 32'h2A, 32'h0,        32'h00007F01, 0, 2, 0, -1, 32'h0);
        vecs[8]  = mk(0, B, 1, 32'h29, 32'h0,        32'hFFFFFFFF, 0, 2, 0, -1, 32'h0);
        vecs[9]  = mk(1, B, 0, 32'h21, 32'h123456AA, 32'h0,        0, 3, 1,  8, 32'h11AA3344);
        vecs[10] = mk(1, H, 0, 32'h22, 32'hFFFFBEEF, 32'h0,        0, 3, 1,  8, 32'h11AABEEF);
        vecs[11] = mk(0, W, 0, 32'h22, 32'h0,        32'h0,        1, 1, 0, -1, 32'h0);
        vecs[12] = mk(0, X, 0, 32'h20, 32'h0,        32'h0,        1, 1, 0, -1, 32'h0);
        vecs[13] = mk(1, H, 0, 32'h21, 32'h00005555, 32'h0,        1, 1, 0,  8, 32'h11AABEEF);
        vecs[14] = mk(1, W, 0, 32'h12, 32'h77777777, 32'h0,        1, 1, 0,  4, 32'hDEADBEEF);
        vecs[15] = mk(0, W, 1, 32'h20, 32'h0,        32'h11AABEEF, 0, 2, 0, -1, 32'h0);
        vecs[16] = mk(1, B, 1, 32'h2B, 32'hFFFFFF55, 32'h0,        0, 3, 1, 10, 32'h80FF7F55);
        vecs[17] = mk(0, B, 0, 32'h2B, 32'h0,        32'h00000055, 0, 2, 0, -1, 32'h0);

        // --- reset state, with memory preload done while in reset
        preload(8,  32'h11223344);
        preload(10, 32'h80FF7F01);
        preload(12, 32'h01020304);
        preload(13, 32'h0BADF00D);
        preload(4,  32'h00000000);
        @(negedge clk);
        check("rst_req_ready",  32'(req_ready),  32'h1);
        check("rst_resp_valid", 32'(resp_valid), 32'h0);
        check("rst_resp_err",   32'(resp_err),   32'h0);
        check("rst_resp_rdata", resp_rdata,      32'h0);
        check("rst_data_addr",  data_addr,       32'h0);
        check("rst_data_wr",    32'(data_wr),    32'h0);
        check("rst_data_out",   data_out,        32'h0);
        rst_n = 1'b1;

        // --- table-driven vectors
        for (int i = 0; i < 18; i++) begin
            do_req(vecs[i].we, vecs[i].size, vecs[i].sgn, vecs[i].addr, vecs[i].wdata,
                   rd, er, lat, wr, da);
            $display("vec %0d we=%0d size=%0d addr=%08h -> rdata=%08h err=%0d lat=%0d wr=%0d",
                     i, vecs[i].we, vecs[i].size, vecs[i].addr, rd, er, lat, wr);
            check($sformatf("v%0d_rdata", i), rd, vecs[i].exp_rdata);
            check($sformatf("v%0d_err", i), 32'(er), 32'(vecs[i].exp_err));
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(vecs[i].exp_lat));
            check($sformatf("v%0d_wr_cycles", i), 32'(wr), 32'(vecs[i].exp_wr));
            check($sformatf("v%0d_data_addr", i), da, {vecs[i].addr[31:2], 2'b00});
            if (vecs[i].mem_idx >= 0)
                check($sformatf("v%0d_mem", i), mem[vecs[i].mem_idx], vecs[i].exp_mem);
        end

        // --- reset during READ of a halfword store
        @(negedge clk);
        req_we = 1'b1; req_size = H; req_signed = 1'b0;
        req_addr = 32'h30; req_wdata = 32'h0000CAFE; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        bad_cnt = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (data_wr || resp_valid) bad_cnt++;
        end
        rst_n = 1'b1;
        check("rst_read_ready", 32'(req_ready), 32'h1);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            if (data_wr || resp_valid) bad_cnt++;
        end
        check("rst_read_no_activity", 32'(bad_cnt), 32'h0);
        check("rst_read_mem", mem[12], 32'h01020304);
        $display("reset-in-READ: stray cycles=%0d mem=%08h", bad_cnt, mem[12]);

        // --- reset during WRITE of a word store: data_wr must drop at once
        @(negedge clk);
        req_we = 1'b1; req_size = W; req_addr = 32'h34;
        req_wdata = 32'h12345678; req_valid = 1'b1;
        @(posedge clk);
        #1 req_valid = 1'b0;
        @(negedge clk);
        check("write_strobe_up", 32'(data_wr), 32'h1);
        rst_n = 1'b0;
        #1;
        check("async_wr_drop", 32'(data_wr), 32'h0);
        bad_cnt = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            if (resp_valid) bad_cnt++;
        end
        rst_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            if (resp_valid || data_wr) bad_cnt++;
        end
        check("rst_write_no_resp", 32'(bad_cnt), 32'h0);
        check("rst_write_mem", mem[13], 32'h0BADF00D);
        $display("reset-in-WRITE: stray cycles=%0d mem=%08h", bad_cnt, mem[13]);

        // --- back-to-back loads with req_valid held high
        @(negedge clk);
        req_we = 1'b0; req_size = W; req_signed = 1'b0;
        req_addr = 32'h20; req_valid = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 6; c++) begin
            @(negedge clk);
            rdy_seen[c] = req_ready;
            rv_seen[c]  = resp_valid;
            rd_seen[c]  = resp_rdata;
            if (c == 4) req_valid = 1'b0;
        end
        check("b2b_ready", {26'd0, rdy_seen[1], rdy_seen[2], rdy_seen[3],
                            rdy_seen[4], rdy_seen[5], rdy_seen[6]}, 32'b001001);
        check("b2b_resp_valid", {26'd0, rv_seen[1], rv_seen[2], rv_seen[3],
                                 rv_seen[4], rv_seen[5], rv_seen[6]}, 32'b010010);
        check("b2b_rdata_first",  rd_seen[2], 32'h11AABEEF);
        check("b2b_rdata_second", rd_seen[5], 32'h11AABEEF);
        $display("back-to-back: rdata=%08h/%08h", rd_seen[2], rd_seen[5]);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Global time limit so the run always terminates.
    initial begin
        #200000;
        $display("FAIL global_timeout: got timeout expected finish");
        $fatal(1, "timeout");
    end

endmodule
